// File: rtl/muldiv_hilo.sv
// HI/LO multiply/divide unit: single-cycle MULT/MULTU, MTHI/MTLO, and a
// 32-iteration radix-2 restoring DIV/DIVU that holds HI/LO until the final write.
module muldiv_hilo #(
  parameter logic [31:0] RESET_HILO = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  output logic        busy,
  output logic [31:0] hi_data,
  output logic [31:0] lo_data
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {S_IDLE = 1'b0, S_DIV = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [31:0] hi, lo;
  logic [31:0] rem, quo, dvs, a_raw;
  logic        neg_q, neg_r, b_zero;

  logic        accept, is_div, is_signed;
  logic [31:0] abs_a, abs_b;
  logic [63:0] prod_s, prod_u;
  logic [32:0] trial;
  logic        ge;
  logic [31:0] rem_nxt, quo_nxt;

  assign accept    = req_valid && (state == S_IDLE) && (req_op <= OP_MTLO);
  assign is_div    = (req_op == OP_DIV) || (req_op == OP_DIVU);
  assign is_signed = (req_op == OP_DIV);
  assign abs_a     = (is_signed && req_a[31]) ? (32'd0 - req_a) : req_a;
  assign abs_b     = (is_signed && req_b[31]) ? (32'd0 - req_b) : req_b;
  assign prod_s    = {{32{req_a[31]}}, req_a} * {{32{req_b[31]}}, req_b};
  assign prod_u    = {32'd0, req_a} * {32'd0, req_b};

  // One restoring step; when ge holds, trial - dvs always fits in 32 bits.
  assign trial   = {rem, quo[31]};
  assign ge      = (trial >= {1'b0, dvs});
  assign rem_nxt = ge ? (trial[31:0] - dvs) : trial[31:0];
  assign quo_nxt = {quo[30:0], ge};

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && is_div) state_nxt = S_DIV;
      S_DIV:  if (cnt == 6'd31)     state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    busy      = (state == S_DIV);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi     <= RESET_HILO;
      lo     <= RESET_HILO;
      cnt    <= 6'd0;
      rem    <= 32'd0;
      quo    <= 32'd0;
      dvs    <= 32'd0;
      a_raw  <= 32'd0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
    end else if (state == S_IDLE) begin
      if (accept) begin
        case (req_op)
          OP_MULT:  {hi, lo} <= prod_s;
          OP_MULTU: {hi, lo} <= prod_u;
          OP_DIV, OP_DIVU: begin
            quo    <= abs_a;
            dvs    <= abs_b;
            a_raw  <= req_a;
            neg_q  <= is_signed && (req_a[31] ^ req_b[31]);
            neg_r  <= is_signed && req_a[31];
            b_zero <= (req_b == 32'd0);
            cnt    <= 6'd0;
            rem    <= 32'd0;
          end
          OP_MTHI: hi <= req_a;
          OP_MTLO: lo <= req_a;
          default: ;
        endcase
      end
    end else begin
      rem <= rem_nxt;
      quo <= quo_nxt;
      cnt <= cnt + 6'd1;
      if (cnt == 6'd31) begin
        // A zero divisor reports the original dividend, not the sign-fixed magnitude.
        if (b_zero) begin
          lo <= 32'hFFFF_FFFF;
          hi <= a_raw;
        end else begin
          lo <= neg_q ? (32'd0 - quo_nxt) : quo_nxt;
          hi <= neg_r ? (32'd0 - rem_nxt) : rem_nxt;
        end
      end
    end
  end

  assign hi_data = hi;
  assign lo_data = lo;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed bench for muldiv_hilo: MTHI/MTLO, multiplies, divides with edge cases,
// request stalling during a divide, and reset abort.
module tb_muldiv_hilo;

  localparam logic [31:0] RST_V = 32'hA5A5_0F0F;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        req_ready, busy;
  logic [31:0] hi_data, lo_data;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_hilo #(.RESET_HILO(RST_V)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .busy(busy),
    .hi_data(hi_data), .lo_data(lo_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
  endtask

  // Divide with busy/hold checks each cycle; optionally present MTHI 0x55 at busy cycle mt_cycle.
  task automatic run_div(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int mt_cycle);
    logic [31:0] pre_hi, pre_lo;
    bit holding;
    pre_hi  = hi_data;
    pre_lo  = lo_data;
    holding = 1'b0;
    issue(op, a, b);
    step();
    req_valid = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      if (i == mt_cycle) begin
        issue(3'd4, 32'h0000_0055, 32'd0);
        holding = 1'b1;
      end else if (!holding) begin
        req_a = $urandom;
        req_b = $urandom;
      end
      chk({tag, "_busy"},  {31'd0, busy}, 32'd1);
      chk({tag, "_ready"}, {31'd0, req_ready}, 32'd0);
      chk({tag, "_hold_hi"}, hi_data, pre_hi);
      chk({tag, "_hold_lo"}, lo_data, pre_lo);
      step();
    end
    chk({tag, "_done_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_hi"}, hi_data, exp_hi);
    chk({tag, "_lo"}, lo_data, exp_lo);
    if (holding) begin
      step();
      req_valid = 1'b0;
      chk({tag, "_mthi_hi"}, hi_data, 32'h0000_0055);
      chk({tag, "_mthi_lo"}, lo_data, exp_lo);
      chk({tag, "_mthi_busy"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_op = 3'd0; req_a = 32'd0; req_b = 32'd0;
    step();
    // reset must win over a simultaneous MTHI
    issue(3'd4, 32'h0000_FFFF, 32'd0);
    step();
    req_valid = 1'b0;
    reset = 1'b0;
    chk("rst_hi", hi_data, RST_V);
    chk("rst_lo", lo_data, RST_V);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);

    issue(3'd4, 32'h1234_5678, 32'd0);
    step();
    chk("mthi_hi", hi_data, 32'h1234_5678);
    chk("mthi_lo", lo_data, RST_V);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    issue(3'd5, 32'hDEAD_BEEF, 32'd0);
    step();
    req_valid = 1'b0;
    chk("mtlo_lo", lo_data, 32'hDEAD_BEEF);
    chk("mtlo_hi", hi_data, 32'h1234_5678);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);

    issue(3'd6, 32'h1111_1111, 32'h2222_2222);
    step();
    issue(3'd7, 32'h3333_3333, 32'h4444_4444);
    step();
    req_valid = 1'b0;
    chk("rsvd_hi", hi_data, 32'h1234_5678);
    chk("rsvd_lo", lo_data, 32'hDEAD_BEEF);
    chk("rsvd_busy", {31'd0, busy}, 32'd0);

    issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
    step();
    chk("mult_hi", hi_data, 32'hFFFF_FFFF);
    chk("mult_lo", lo_data, 32'hFFFF_FFFE);
    issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
    step();
    req_valid = 1'b0;
    chk("multu_hi", hi_data, 32'h0000_0001);
    chk("multu_lo", lo_data, 32'hFFFF_FFFE);
    issue(3'd0, 32'h8000_0000, 32'h8000_0000);
    step();
    req_valid = 1'b0;
    chk("mult_min_hi", hi_data, 32'h4000_0000);
    chk("mult_min_lo", lo_data, 32'h0000_0000);

    issue(3'd4, 32'd0, 32'd0);
    step();
    issue(3'd5, 32'd0, 32'd0);
    step();
    req_valid = 1'b0;

    run_div("div_m7_2",   3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_div("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    run_div("divu_by0",   3'd3, 32'h0000_0064, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 0);
    run_div("div_ovf",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
    run_div("div_neg_by0", 3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0);
    run_div("div_7_m2",   3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0);
    run_div("div_m7_m2",  3'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3, 0);
    run_div("divu_big",   3'd3, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 0);
    run_div("divu_stall", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 5);

    // Reset at busy cycle 10 of DIV 1000/3
    issue(3'd2, 32'd1000, 32'd3);
    step();
    req_valid = 1'b0;
    for (int i = 1; i < 10; i++) step();
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_hi", hi_data, RST_V);
    chk("abort_lo", lo_data, RST_V);
    for (int i = 0; i < 30; i++) step();
    chk("abort_hi_late", hi_data, RST_V);
    chk("abort_lo_late", lo_data, RST_V);
    issue(3'd1, 32'd3, 32'd4);
    step();
    req_valid = 1'b0;
    chk("post_multu_hi", hi_data, 32'd0);
    chk("post_multu_lo", lo_data, 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
MULDIV_HILO -- requirements
Module: muldiv_hilo

Interface
REQ-001 Clock is `clk`, reset is `reset`; one clock; reset is synchronous and active-high.
REQ-002 Parameter RESET_HILO, default 32'h0000_0000, is the value loaded into HI and LO on reset.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  request present this cycle.
REQ-006 req_op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7 reserved.
REQ-007 req_a  in  32  rs operand: dividend, multiplicand, or MTHI/MTLO data.
REQ-008 req_b  in  32  rt operand: divisor or multiplier.
REQ-009 req_ready  out  1  block can accept a request this cycle.
REQ-010 busy  out  1  divide in progress; the pipeline stalls MFHI/MFLO/MULT/DIV/MTHI/MTLO while high.
REQ-011 hi_data  out  32  current HI register, registered output.
REQ-012 lo_data  out  32  current LO register, registered output.

Function
REQ-013 A request is accepted at a rising edge where req_valid=1, req_ready=1 and req_op<=5.
REQ-014 Requests with req_op 6-7, or presented while req_ready=0, are ignored with no state change; upstream holds them until accepted.
REQ-015 FSM states: IDLE and DIV; req_ready=(state==IDLE); busy=(state==DIV).
REQ-016 MTHI/MTLO: on the accept edge HI (resp. LO) <= req_a, the other register is unchanged, and state stays IDLE; visible on hi_data/lo_data the next cycle.
REQ-017 MULT/MULTU: on the accept edge {HI,LO} <= 64-bit product (signed x signed, or unsigned x unsigned); latency 1 cycle; no busy.
REQ-018 DIV/DIVU: on the accept edge, latch the dividend/divisor magnitudes (absolute values for DIV), latch the sign flags, clear the 6-bit counter, clear the partial remainder, and enter DIV.
REQ-019 In DIV, each edge performs one radix-2 restoring iteration (shift, trial subtract, quotient bit) and increments the counter.
REQ-020 On the edge that completes counter==31 (the 32nd busy cycle), write LO=quotient and HI=remainder, then return to IDLE.
REQ-021 Busy is high for exactly 32 cycles after accept; req_ready is high again in the cycle after the write.
REQ-022 Signed fix-up is applied at the final write: the quotient is negated if the operand signs differ, and the remainder takes the sign of the dividend.
REQ-023 Divisor==0 (DIV or DIVU): still 32 busy cycles; result HI=req_a as latched, LO=32'hFFFF_FFFF.
REQ-024 DIV 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0x0000_0000; no exception.
REQ-025 During DIV, hi_data/lo_data hold their pre-divide values until the final write edge.
REQ-026 Latched operands are internal; changes on req_a/req_b during DIV have no effect.

Reset
REQ-027 When reset=1 at an edge: state<=IDLE, counter<=0, HI<=RESET_HILO, LO<=RESET_HILO, and partial remainder/quotient are cleared.
REQ-028 Reset has priority over any request in the same cycle.
REQ-029 Reset during DIV aborts the divide, discards its result, and sets busy=0 and req_ready=1 in the next cycle.

Verification
REQ-030 Reset, then MTHI 0x1234_5678, then MTLO 0xDEAD_BEEF in consecutive cycles -> hi_data=0x1234_5678 one cycle after the first, lo_data=0xDEAD_BEEF one cycle after the second; busy never asserts.
REQ-031 MULT 0xFFFF_FFFF x 0x0000_0002 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFFE; MULTU same operands -> HI=0x0000_0001, LO=0xFFFF_FFFE; each visible the cycle after accept.
REQ-032 With HI=LO=0, DIV 0xFFFF_FFF9 (-7) / 0x0000_0002 -> busy high exactly 32 cycles with hi/lo still 0, then LO=0xFFFF_FFFD, HI=0xFFFF_FFFF; DIVU 100/7 -> LO=14, HI=2.
REQ-033 DIVU 0x64 / 0 -> HI=0x0000_0064, LO=0xFFFF_FFFF after 32 busy cycles; DIV 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
REQ-034 MTHI 0x55 presented at busy cycle 5 of a DIV -> ignored while req_ready=0; HI ends at the divide result; the held MTHI is accepted the cycle req_ready rises, then HI=0x55.
REQ-035 Reset asserted at busy cycle 10 of DIV 1000/3 -> next cycle busy=0, req_ready=1, HI=LO=RESET_HILO; a following MULTU 3x4 gives LO=12, HI=0.
